// File: rtl/mem_access_unit.sv
// Multi-cycle MEM-stage memory access unit.
// Checks natural alignment, issues one registered RAM request at a time and
// stalls the pipeline until the RAM acknowledges or the bus times out.
// Load results are lane-extracted and sign/zero-extended for writeback.
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic                    read_flag,
    input  logic                    write_flag,
    input  logic                    sign_ext_flag,
    input  logic [1:0]              size,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic                    flush,
    output logic                    stall_req,
    output logic                    ram_en,
    output logic [DATA_WIDTH/8-1:0] ram_write_en,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_write_data,
    input  logic [DATA_WIDTH-1:0]   ram_read_data,
    input  logic                    ram_ready,
    output logic [DATA_WIDTH-1:0]   load_data,
    output logic                    load_valid,
    output logic                    addr_error,
    output logic                    bus_error,
    output logic [ADDR_WIDTH-1:0]   bad_addr
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam int CNTW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state_q, state_d;
    logic                    ram_en_q, ram_en_d;
    logic [BYTES-1:0]        ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_wd_q, ram_wd_d;
    logic [DATA_WIDTH-1:0]   load_data_q, load_data_d;
    logic                    load_valid_q, load_valid_d;
    logic                    addr_error_q, addr_error_d;
    logic                    bus_error_q, bus_error_d;
    logic [ADDR_WIDTH-1:0]   bad_addr_q, bad_addr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [OFFW-1:0]         off_q, off_d;
    logic [1:0]              size_q, size_d;
    logic                    sext_q, sext_d;
    logic                    is_load_q, is_load_d;
    logic                    drop_q, drop_d;
    logic [CNTW-1:0]         cnt_q, cnt_d;

    logic                    accept, misaligned, timeout_hit, sbit;
    logic [OFFW-1:0]         off;
    logic [BYTES-1:0]        req_bmask;
    logic [DATA_WIDTH-1:0]   rd_shift, rd_mask, rd_ext;

    // Byte-lane mask for an access size, right-justified.
    function automatic logic [BYTES-1:0] size_mask(input logic [1:0] s);
        case (s)
            2'd0:    return BYTES'(1);
            2'd1:    return BYTES'(3);
            2'd2:    return BYTES'(15);
            default: return '1;
        endcase
    endfunction

    // Expand a byte-lane mask into a bit mask.
    function automatic logic [DATA_WIDTH-1:0] lanes_to_bits(input logic [BYTES-1:0] m);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < BYTES; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    // Request decode: acceptance, alignment and lane offset.
    always_comb begin
        off        = addr[OFFW-1:0];
        req_bmask  = size_mask(size);
        accept     = (state_q == IDLE) && req_valid && (read_flag ^ write_flag);
        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = addr[0];
            2'd2:    misaligned = |addr[1:0];
            default: misaligned = (DATA_WIDTH == 32) ? 1'b1 : |addr[2:0];
        endcase
        // Counter holds the number of completed no-ready BUSY cycles; this
        // cycle is the last allowed one when it would bring it to TIMEOUT.
        timeout_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT));
    end

    // Load path: shift the addressed lanes down, mask to size, extend.
    always_comb begin
        rd_shift = ram_read_data >> {off_q, 3'b000};
        rd_mask  = lanes_to_bits(size_mask(size_q));
        case (size_q)
            2'd0:    sbit = rd_shift[7];
            2'd1:    sbit = rd_shift[15];
            2'd2:    sbit = rd_shift[31];
            default: sbit = rd_shift[DATA_WIDTH-1];
        endcase
        rd_ext = (rd_shift & rd_mask) | ((sext_q && sbit) ? ~rd_mask : '0);
    end

    // Next-state logic for the IDLE/BUSY controller and its registered outputs.
    always_comb begin
        state_d      = state_q;
        ram_en_d     = ram_en_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_wd_d     = ram_wd_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        addr_error_d = 1'b0;
        bus_error_d  = 1'b0;
        bad_addr_d   = bad_addr_q;
        addr_d       = addr_q;
        off_d        = off_q;
        size_d       = size_q;
        sext_d       = sext_q;
        is_load_d    = is_load_q;
        drop_d       = drop_q;
        cnt_d        = cnt_q;
        stall_req    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        addr_error_d = 1'b1;
                        bad_addr_d   = addr;
                    end else begin
                        stall_req  = 1'b1;
                        state_d    = BUSY;
                        ram_en_d   = 1'b1;
                        ram_addr_d = {addr[ADDR_WIDTH-1:OFFW], OFFW'(0)};
                        ram_we_d   = write_flag ? (req_bmask << off) : '0;
                        ram_wd_d   = write_flag ?
                                     ((write_data & lanes_to_bits(req_bmask)) << {off, 3'b000}) : '0;
                        addr_d     = addr;
                        off_d      = off;
                        size_d     = size;
                        sext_d     = sign_ext_flag;
                        is_load_d  = read_flag;
                        drop_d     = 1'b0;
                        cnt_d      = '0;
                    end
                end
            end
            BUSY: begin
                stall_req = 1'b1;
                drop_d    = drop_q | flush;
                if (ram_ready) begin
                    state_d  = IDLE;
                    ram_en_d = 1'b0;
                    ram_we_d = '0;
                    ram_wd_d = '0;
                    drop_d   = 1'b0;
                    if (is_load_q) begin
                        load_data_d  = rd_ext;
                        load_valid_d = !(drop_q || flush);
                    end
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    ram_en_d    = 1'b0;
                    ram_we_d    = '0;
                    ram_wd_d    = '0;
                    drop_d      = 1'b0;
                    bus_error_d = 1'b1;
                    bad_addr_d  = addr_q;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ram_en_q     <= 1'b0;
            ram_we_q     <= '0;
            ram_addr_q   <= '0;
            ram_wd_q     <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            addr_error_q <= 1'b0;
            bus_error_q  <= 1'b0;
            bad_addr_q   <= '0;
            addr_q       <= '0;
            off_q        <= '0;
            size_q       <= '0;
            sext_q       <= 1'b0;
            is_load_q    <= 1'b0;
            drop_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wd_q     <= ram_wd_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            addr_error_q <= addr_error_d;
            bus_error_q  <= bus_error_d;
            bad_addr_q   <= bad_addr_d;
            addr_q       <= addr_d;
            off_q        <= off_d;
            size_q       <= size_d;
            sext_q       <= sext_d;
            is_load_q    <= is_load_d;
            drop_q       <= drop_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ram_en         = ram_en_q;
    assign ram_write_en   = ram_we_q;
    assign ram_addr       = ram_addr_q;
    assign ram_write_data = ram_wd_q;
    assign load_data      = load_data_q;
    assign load_valid     = load_valid_q;
    assign addr_error     = addr_error_q;
    assign bus_error      = bus_error_q;
    assign bad_addr       = bad_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit instance (TIMEOUT=4) and a
// 64-bit instance. Expected load results and error addresses are queued when
// a request is driven and compared when the DUT reports them.
module tb_mem_access_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // 32-bit instance
    logic        a_req, a_rd, a_wr, a_sx, a_flush, a_rdy;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wd, a_rrd;
    logic        a_stall, a_en, a_lv, a_ae, a_be;
    logic [3:0]  a_we;
    logic [31:0] a_raddr, a_rwd, a_ld, a_bad;

    // 64-bit instance
    logic        b_req, b_rd, b_wr, b_sx, b_flush, b_rdy;
    logic [1:0]  b_size;
    logic [31:0] b_addr;
    logic [63:0] b_wd, b_rrd;
    logic        b_stall, b_en, b_lv, b_ae, b_be;
    logic [7:0]  b_we;
    logic [31:0] b_raddr, b_bad;
    logic [63:0] b_rwd, b_ld;

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(4)) u32 (
        .clk(clk), .rst(rst), .req_valid(a_req), .read_flag(a_rd), .write_flag(a_wr),
        .sign_ext_flag(a_sx), .size(a_size), .addr(a_addr), .write_data(a_wd),
        .flush(a_flush), .stall_req(a_stall), .ram_en(a_en), .ram_write_en(a_we),
        .ram_addr(a_raddr), .ram_write_data(a_rwd), .ram_read_data(a_rrd),
        .ram_ready(a_rdy), .load_data(a_ld), .load_valid(a_lv), .addr_error(a_ae),
        .bus_error(a_be), .bad_addr(a_bad));

    mem_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(16)) u64 (
        .clk(clk), .rst(rst), .req_valid(b_req), .read_flag(b_rd), .write_flag(b_wr),
        .sign_ext_flag(b_sx), .size(b_size), .addr(b_addr), .write_data(b_wd),
        .flush(b_flush), .stall_req(b_stall), .ram_en(b_en), .ram_write_en(b_we),
        .ram_addr(b_raddr), .ram_write_data(b_rwd), .ram_read_data(b_rrd),
        .ram_ready(b_rdy), .load_data(b_ld), .load_valid(b_lv), .addr_error(b_ae),
        .bus_error(b_be), .bad_addr(b_bad));

    int npass = 0, ntot = 0, nfail = 0;
    logic [63:0] a_ldq[$], a_aeq[$], a_beq[$], b_ldq[$], b_aeq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard: every reported result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_lv || a_ae || a_be) chk("a_onehot", 64'($countones({a_lv, a_ae, a_be})), 64'd1);
            if (a_lv) begin
                chk("a_lv_expected", {63'b0, a_lv}, {63'b0, a_ldq.size() != 0});
                if (a_ldq.size() != 0) chk("a_load_data", {32'b0, a_ld}, a_ldq.pop_front());
            end
            if (a_ae) begin
                chk("a_ae_expected", {63'b0, a_ae}, {63'b0, a_aeq.size() != 0});
                if (a_aeq.size() != 0) chk("a_ae_bad_addr", {32'b0, a_bad}, a_aeq.pop_front());
            end
            if (a_be) begin
                chk("a_be_expected", {63'b0, a_be}, {63'b0, a_beq.size() != 0});
                if (a_beq.size() != 0) chk("a_be_bad_addr", {32'b0, a_bad}, a_beq.pop_front());
            end
            if (b_lv) begin
                chk("b_lv_expected", {63'b0, b_lv}, {63'b0, b_ldq.size() != 0});
                if (b_ldq.size() != 0) chk("b_load_data", b_ld, b_ldq.pop_front());
            end
            if (b_ae) begin
                chk("b_ae_expected", {63'b0, b_ae}, {63'b0, b_aeq.size() != 0});
                if (b_aeq.size() != 0) chk("b_ae_bad_addr", {32'b0, b_bad}, b_aeq.pop_front());
            end
            chk("b_no_bus_error", {63'b0, b_be}, 64'd0);
        end
    end

    initial begin
        rst = 1'b1;
        {a_req, a_rd, a_wr, a_sx, a_flush, a_rdy, a_size} = '0;
        a_addr = '0; a_wd = '0; a_rrd = '0;
        {b_req, b_rd, b_wr, b_sx, b_flush, b_rdy, b_size} = '0;
        b_addr = '0; b_wd = '0; b_rrd = '0;
        repeat (2) tick();
        smp();
        chk("rst_a_ctrl", {58'b0, a_en, a_lv, a_ae, a_be, a_stall, 1'b0}, 64'd0);
        chk("rst_a_we", {60'b0, a_we}, 64'd0);
        chk("rst_a_data", {a_raddr, a_rwd}, 64'd0);
        chk("rst_a_ld_bad", {a_ld, a_bad}, 64'd0);
        chk("rst_b_ctrl", {55'b0, b_en, b_lv, b_ae, b_be, b_stall, 3'b0}, 64'd0);
        chk("rst_b_ld", b_ld, 64'd0);
        tick(); rst = 1'b0;

        // Byte store at 0x1003, ready on the 2nd BUSY cycle
        tick(); a_req = 1; a_wr = 1; a_size = 0; a_addr = 32'h1003; a_wd = 32'hAB;
        smp(); chk("bs_stall_accept", {63'b0, a_stall}, 64'd1);
        chk("bs_en_accept", {63'b0, a_en}, 64'd0);
        tick(); a_req = 0; a_wr = 0;
        smp(); chk("bs_en", {63'b0, a_en}, 64'd1);
        chk("bs_addr", {32'b0, a_raddr}, 64'h1000);
        chk("bs_we", {60'b0, a_we}, 64'h8);
        chk("bs_wdata", {32'b0, a_rwd}, 64'hAB000000);
        chk("bs_stall_b1", {63'b0, a_stall}, 64'd1);
        tick(); a_rdy = 1;
        smp(); chk("bs_stall_b2", {63'b0, a_stall}, 64'd1);
        chk("bs_hold", {27'b0, a_en, a_we, a_rwd}, {27'b0, 1'b1, 4'h8, 32'hAB000000});
        tick(); a_rdy = 0;
        smp(); chk("bs_done", {27'b0, a_en, a_we, a_rwd}, 64'd0);
        chk("bs_stall_done", {62'b0, a_stall, a_lv}, 64'd0);

        // Half loads at 0x2002, signed then unsigned
        for (int k = 0; k < 2; k++) begin
            tick(); a_req = 1; a_rd = 1; a_sx = (k == 0); a_size = 1; a_addr = 32'h2002;
            a_ldq.push_back((k == 0) ? 64'hFFFF8001 : 64'h00008001);
            smp(); chk("hl_stall", {63'b0, a_stall}, 64'd1);
            tick(); a_req = 0; a_rd = 0; a_rdy = 1; a_rrd = 32'h8001FFFF;
            smp(); chk("hl_req", {27'b0, a_en, a_we, a_raddr}, {27'b0, 1'b1, 4'h0, 32'h2000});
            tick(); a_rdy = 0;
            smp(); chk("hl_valid", {62'b0, a_lv, a_stall}, 64'b10);
            tick();
            smp(); chk("hl_pulse", {63'b0, a_lv}, 64'd0);
        end

        // Misaligned word store
        tick(); a_req = 1; a_wr = 1; a_size = 2; a_addr = 32'h3001; a_wd = 32'h55;
        a_aeq.push_back(64'h3001);
        smp(); chk("ma_stall", {63'b0, a_stall}, 64'd0);
        tick(); a_req = 0; a_wr = 0;
        smp(); chk("ma_err", {61'b0, a_ae, a_en, a_stall}, 64'b100);
        chk("ma_bad", {32'b0, a_bad}, 64'h3001);
        tick();
        smp(); chk("ma_pulse", {62'b0, a_ae, a_en}, 64'd0);
        chk("ma_bad_held", {32'b0, a_bad}, 64'h3001);

        // read_flag and write_flag together: no access
        tick(); a_req = 1; a_rd = 1; a_wr = 1; a_size = 2; a_addr = 32'h3005;
        smp(); chk("both_stall", {63'b0, a_stall}, 64'd0);
        tick(); a_req = 0; a_rd = 0; a_wr = 0;
        smp(); chk("both_none", {62'b0, a_en, a_ae}, 64'd0);

        // Timeout: load at 0x4000, never ready
        tick(); a_req = 1; a_rd = 1; a_size = 2; a_addr = 32'h4000;
        a_beq.push_back(64'h4000);
        smp(); chk("to_stall", {63'b0, a_stall}, 64'd1);
        tick(); a_req = 0; a_rd = 0;
        for (int i = 0; i < 4; i++) begin
            smp(); chk("to_busy", {61'b0, a_en, a_be, a_stall}, 64'b101);
            tick();
        end
        smp(); chk("to_err", {60'b0, a_be, a_en, a_stall, a_lv}, 64'b1000);
        chk("to_bad", {32'b0, a_bad}, 64'h4000);
        tick();
        smp(); chk("to_pulse", {63'b0, a_be}, 64'd0);

        // Flushed load: RAM completes, result written but not reported
        tick(); a_req = 1; a_rd = 1; a_sx = 0; a_size = 2; a_addr = 32'h10;
        smp(); chk("fl_stall", {63'b0, a_stall}, 64'd1);
        tick(); a_req = 0; a_rd = 0; a_flush = 1;
        smp(); chk("fl_en", {63'b0, a_en}, 64'd1);
        tick(); a_flush = 0; a_rdy = 1; a_rrd = 32'h12345678;
        smp(); chk("fl_stall_b2", {63'b0, a_stall}, 64'd1);
        tick(); a_rdy = 0;
        smp(); chk("fl_no_valid", {62'b0, a_lv, a_stall}, 64'd0);
        chk("fl_data", {32'b0, a_ld}, 64'h12345678);

        // Following signed byte load at 0x15 is reported again
        tick(); a_req = 1; a_rd = 1; a_sx = 1; a_size = 0; a_addr = 32'h15;
        a_ldq.push_back(64'hFFFFFFC3);
        smp();
        tick(); a_req = 0; a_rd = 0; a_rdy = 1; a_rrd = 32'h0000C300;
        smp();
        tick(); a_rdy = 0;
        smp(); chk("fb_valid", {63'b0, a_lv}, 64'd1);

        // Reset while BUSY, then a new store is accepted
        tick(); a_req = 1; a_rd = 1; a_size = 2; a_addr = 32'h20;
        smp();
        tick(); a_req = 0; a_rd = 0; rst = 1;
        smp(); chk("rb_busy", {63'b0, a_en}, 64'd1);
        tick(); rst = 0;
        smp(); chk("rb_ctrl", {57'b0, a_en, a_lv, a_ae, a_be, a_stall, 2'b0}, 64'd0);
        chk("rb_ram", {a_raddr, a_rwd}, 64'd0);
        chk("rb_ld_bad", {a_ld, a_bad}, 64'd0);
        chk("rb_we", {60'b0, a_we}, 64'd0);
        tick(); a_req = 1; a_wr = 1; a_size = 2; a_addr = 32'h24; a_wd = 32'hDEADBEEF;
        smp(); chk("rb_new_stall", {63'b0, a_stall}, 64'd1);
        tick(); a_req = 0; a_wr = 0; a_rdy = 1;
        smp(); chk("rb_new_req", {27'b0, a_en, a_we, a_raddr}, {27'b0, 1'b1, 4'hF, 32'h24});
        chk("rb_new_wd", {32'b0, a_rwd}, 64'hDEADBEEF);
        tick(); a_rdy = 0;
        smp(); chk("rb_new_done", {63'b0, a_en}, 64'd0);

        // 64-bit: dword load, misaligned dword, half store in upper lanes
        tick(); b_req = 1; b_rd = 1; b_size = 3; b_addr = 32'h8;
        b_ldq.push_back(64'h1122334455667788);
        smp(); chk("dw_stall", {63'b0, b_stall}, 64'd1);
        tick(); b_req = 0; b_rd = 0; b_rdy = 1; b_rrd = 64'h1122334455667788;
        smp(); chk("dw_req", {31'b0, b_en, b_raddr}, {31'b0, 1'b1, 32'h8});
        tick(); b_rdy = 0;
        smp(); chk("dw_valid", {63'b0, b_lv}, 64'd1);
        tick(); b_req = 1; b_rd = 1; b_size = 3; b_addr = 32'hC;
        b_aeq.push_back(64'hC);
        smp(); chk("dw_ma_stall", {63'b0, b_stall}, 64'd0);
        tick(); b_req = 0; b_rd = 0;
        smp(); chk("dw_ma_err", {62'b0, b_ae, b_en}, 64'b10);
        tick(); b_req = 1; b_wr = 1; b_size = 1; b_addr = 32'h16; b_wd = 64'hFFFFFFFFFFFFBEEF;
        smp();
        tick(); b_req = 0; b_wr = 0; b_rdy = 1;
        smp(); chk("hs64_we", {56'b0, b_we}, 64'hC0);
        chk("hs64_wd", b_rwd, 64'hBEEF000000000000);
        chk("hs64_addr", {32'b0, b_raddr}, 64'h10);
        tick(); b_rdy = 0;
        smp(); chk("hs64_done", {63'b0, b_en}, 64'd0);

        tick(); smp();
        chk("a_ldq_empty", 64'(a_ldq.size()), 64'd0);
        chk("a_errq_empty", 64'(a_aeq.size() + a_beq.size()), 64'd0);
        chk("b_q_empty", 64'(b_ldq.size() + b_aeq.size()), 64'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
